// File: rtl/mux_pipe_n.sv
// N:1 data selector with a registered output stage and a 2-entry skid buffer.
// Out-of-range selects are forwarded as a zero-data beat flagged with out_err.
module mux_pipe_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    if (NUM_IN < 2 || (32'd1 << SEL_W) < NUM_IN) begin : g_param_check
        $error("mux_pipe_n: NUM_IN must be >= 2 and 2**SEL_W >= NUM_IN");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Returns {err, data}; an unmatched index yields err=1 with zero data.
    function automatic logic [WIDTH:0] select_f(input logic [NUM_IN*WIDTH-1:0] d,
                                                input logic [SEL_W-1:0]        s);
        logic [WIDTH:0] r;
        r = {1'b1, {WIDTH{1'b0}}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (s == SEL_W'(k)) begin
                r = {1'b0, d[k*WIDTH +: WIDTH]};
            end
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic               main_err_q, main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q, skid_err_d;

    logic               acc_s;
    logic               del_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic               sel_err_s;
    logic               load_main_sel_s;
    logic               load_skid_s;
    logic               main_from_skid_s;

    assign acc_s                  = in_valid & in_ready_q;
    assign del_s                  = out_valid_q & out_ready;
    assign {sel_err_s, sel_data_s} = select_f(in_data, in_sel);

    // State register plus the handshake flags decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state logic for the MAIN/SKID occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc_s) state_d = ST_ONE;
                else       state_d = ST_EMPTY;
            end
            ST_ONE: begin
                if (acc_s && !del_s)      state_d = ST_FULL;
                else if (!acc_s && del_s) state_d = ST_EMPTY;
                else                      state_d = ST_ONE;
            end
            ST_FULL: begin
                if (del_s) state_d = ST_ONE;
                else       state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output decode: register load enables and next handshake flags.
    always_comb begin
        load_main_sel_s  = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        case (state_q)
            ST_EMPTY: load_main_sel_s = acc_s;
            ST_ONE: begin
                load_main_sel_s = acc_s & del_s;
                load_skid_s     = acc_s & ~del_s;
            end
            ST_FULL:  main_from_skid_s = del_s;
            default: begin
                load_main_sel_s  = 1'b0;
                load_skid_s      = 1'b0;
                main_from_skid_s = 1'b0;
            end
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // Datapath next values; SKID always drains into MAIN before new data.
    always_comb begin
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (main_from_skid_s) begin
            main_data_d = skid_data_q;
            main_err_d  = skid_err_q;
        end else if (load_main_sel_s) begin
            main_data_d = sel_data_s;
            main_err_d  = sel_err_s;
        end else begin
            main_data_d = main_data_q;
            main_err_d  = main_err_q;
        end
        if (load_skid_s) begin
            skid_data_d = sel_data_s;
            skid_err_d  = sel_err_s;
        end else begin
            skid_data_d = skid_data_q;
            skid_err_d  = skid_err_q;
        end
    end

    // MAIN and SKID data registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_data_q <= {WIDTH{1'b0}};
            main_err_q  <= 1'b0;
            skid_data_q <= {WIDTH{1'b0}};
            skid_err_q  <= 1'b0;
        end else begin
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: three configurations (4x32, 3x8, 5x8)
// driven with directed beats and a randomised handshake stream.
module tb_mux_pipe_n;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // ---------------- instance A: WIDTH=32 NUM_IN=4 ----------------
    logic [127:0] in_data_a;
    logic [1:0]   in_sel_a;
    logic         in_valid_a, in_ready_a, out_err_a, out_valid_a, out_ready_a;
    logic [31:0]  out_data_a;
    logic [32:0]  sb_a[$];

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut_a (
        .clk(clk), .rstn(rstn), .in_data(in_data_a), .in_sel(in_sel_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(out_ready_a));

    // ---------------- instance B: WIDTH=8 NUM_IN=5 ----------------
    logic [39:0]  in_data_b;
    logic [2:0]   in_sel_b;
    logic         in_valid_b, in_ready_b, out_err_b, out_valid_b, out_ready_b;
    logic [7:0]   out_data_b;
    logic [8:0]   sb_b[$];
    int           delivered_b = 0;

    mux_pipe_n #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u_dut_b (
        .clk(clk), .rstn(rstn), .in_data(in_data_b), .in_sel(in_sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(out_ready_b));

    // ---------------- instance C: WIDTH=8 NUM_IN=3 ----------------
    logic [23:0]  in_data_c;
    logic [1:0]   in_sel_c;
    logic         in_valid_c, in_ready_c, out_err_c, out_valid_c, out_ready_c;
    logic [7:0]   out_data_c;
    logic [8:0]   sb_c[$];

    mux_pipe_n #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut_c (
        .clk(clk), .rstn(rstn), .in_data(in_data_c), .in_sel(in_sel_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .out_data(out_data_c),
        .out_err(out_err_c), .out_valid(out_valid_c), .out_ready(out_ready_c));

    localparam logic [31:0] VA = 32'hAAAA_0001;
    localparam logic [31:0] VB = 32'hBBBB_0002;
    localparam logic [31:0] VC = 32'hCCCC_0003;
    localparam logic [31:0] VD = 32'hDDDD_0004;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors: a beat retires at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rstn && out_valid_a && out_ready_a) begin
            if (sb_a.size() == 0) check("a_unexpected_beat", {31'd0, out_err_a, out_data_a}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("a_beat", {31'd0, out_err_a, out_data_a}, {31'd0, sb_a.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rstn && out_valid_b && out_ready_b) begin
            delivered_b++;
            if (sb_b.size() == 0) check("b_unexpected_beat", {55'd0, out_err_b, out_data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("b_beat", {55'd0, out_err_b, out_data_b}, {55'd0, sb_b.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rstn && out_valid_c && out_ready_c) begin
            if (sb_c.size() == 0) check("c_unexpected_beat", {55'd0, out_err_c, out_data_c}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("c_beat", {55'd0, out_err_c, out_data_c}, {55'd0, sb_c.pop_front()});
        end
    end

    // Offer one beat, push its expectation when accepted, return cycles stalled.
    task automatic send_a(input logic [1:0] sel, input logic [32:0] exp, output int waits);
        bit ok = 1'b0;
        waits = 0;
        in_sel_a = sel; in_valid_a = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready_a) begin sb_a.push_back(exp); ok = 1'b1; end
            else waits++;
            @(posedge clk); #1;
        end
        if (!ok) check("a_accept_timeout", 64'd0, 64'd1);
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] sel, input logic [8:0] exp);
        bit ok = 1'b0;
        in_sel_b = sel; in_valid_b = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready_b) begin sb_b.push_back(exp); ok = 1'b1; end
            @(posedge clk); #1;
        end
        if (!ok) check("b_accept_timeout", 64'd0, 64'd1);
        in_valid_b = 1'b0;
    endtask

    task automatic send_c(input logic [1:0] sel, input logic [8:0] exp);
        bit ok = 1'b0;
        in_sel_c = sel; in_valid_c = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready_c) begin sb_c.push_back(exp); ok = 1'b1; end
            @(posedge clk); #1;
        end
        if (!ok) check("c_accept_timeout", 64'd0, 64'd1);
        in_valid_c = 1'b0;
    endtask

    initial begin
        int w;
        bit done_b = 1'b0;

        rstn = 1'b0;
        in_data_a = 128'd0; in_sel_a = 2'd0; in_valid_a = 1'b0; out_ready_a = 1'b0;
        in_data_b = 40'd0;  in_sel_b = 3'd0; in_valid_b = 1'b0; out_ready_b = 1'b0;
        in_data_c = 24'd0;  in_sel_c = 2'd0; in_valid_c = 1'b0; out_ready_c = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // T1: reset values, then an asynchronous mid-cycle reset
        check("t1_out_valid", {63'd0, out_valid_a}, 64'd0);
        check("t1_out_data",  {32'd0, out_data_a},  64'd0);
        check("t1_out_err",   {63'd0, out_err_a},   64'd0);
        check("t1_in_ready",  {63'd0, in_ready_a},  64'd1);
        in_data_a = {VD, VC, VB, VA};
        send_a(2'd1, {1'b0, VB}, w);
        check("t1_loaded_valid", {63'd0, out_valid_a}, 64'd1);
        #3 rstn = 1'b0;
        #1;
        check("t1_async_valid", {63'd0, out_valid_a}, 64'd0);
        check("t1_async_data",  {32'd0, out_data_a},  64'd0);
        sb_a.delete();
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        check("t1_release_ready", {63'd0, in_ready_a}, 64'd1);

        // T2: streaming A,B,C,D at full rate
        out_ready_a = 1'b1;
        send_a(2'd0, {1'b0, VA}, w);
        check("t2_latency_valid", {63'd0, out_valid_a}, 64'd1);
        check("t2_stall0", 64'(w), 64'd0);
        send_a(2'd1, {1'b0, VB}, w); check("t2_stall1", 64'(w), 64'd0);
        send_a(2'd2, {1'b0, VC}, w); check("t2_stall2", 64'(w), 64'd0);
        send_a(2'd3, {1'b0, VD}, w); check("t2_stall3", 64'(w), 64'd0);
        repeat (3) @(negedge clk);
        check("t2_drained", 64'(sb_a.size()), 64'd0);
        check("t2_in_ready", {63'd0, in_ready_a}, 64'd1);

        // T3: back-pressure fills the skid, output holds B
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        send_a(2'd1, {1'b0, VB}, w);
        send_a(2'd2, {1'b0, VC}, w);
        check("t3_full_ready", {63'd0, in_ready_a}, 64'd0);
        check("t3_full_data",  {32'd0, out_data_a}, {32'd0, VB});
        repeat (3) @(negedge clk);
        check("t3_hold_data",  {32'd0, out_data_a}, {32'd0, VB});
        check("t3_hold_err",   {63'd0, out_err_a},  64'd0);
        check("t3_hold_ready", {63'd0, in_ready_a}, 64'd0);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_drained", 64'(sb_a.size()), 64'd0);
        check("t3_ready_back", {63'd0, in_ready_a}, 64'd1);

        // T5: reset while FULL loses both beats
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        send_a(2'd0, {1'b0, VA}, w);
        send_a(2'd3, {1'b0, VD}, w);
        check("t5_full_ready", {63'd0, in_ready_a}, 64'd0);
        #2 rstn = 1'b0;
        #1;
        check("t5_async_valid", {63'd0, out_valid_a}, 64'd0);
        check("t5_async_data",  {32'd0, out_data_a},  64'd0);
        sb_a.delete();
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        check("t5_release_ready", {63'd0, in_ready_a}, 64'd1);
        out_ready_a = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_beats", {63'd0, out_valid_a}, 64'd0);

        // T4: out-of-range select on the 3-input instance
        @(posedge clk); #1;
        out_ready_c = 1'b1;
        in_data_c = {8'h33, 8'h22, 8'h11};
        send_c(2'd3, {1'b1, 8'h00});
        send_c(2'd0, {1'b0, 8'h11});
        send_c(2'd2, {1'b0, 8'h33});
        send_c(2'd3, {1'b1, 8'h00});
        send_c(2'd1, {1'b0, 8'h22});
        repeat (3) @(negedge clk);
        check("t4_drained", 64'(sb_c.size()), 64'd0);

        // T6: random handshake on the 5-input instance
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [39:0] d;
                    int          s;
                    logic [8:0]  e;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    d = {$urandom(), 8'($urandom())};
                    s = $urandom_range(0, 7);
                    if (s < 5) e = {1'b0, d[s*8 +: 8]};
                    else       e = {1'b1, 8'h00};
                    in_data_b = d;
                    send_b(3'(s), e);
                end
                done_b = 1'b1;
            end
            begin
                while (!done_b) begin
                    @(posedge clk); #1;
                    out_ready_b = ($urandom_range(0, 9) < 7);
                end
            end
        join
        out_ready_b = 1'b1;
        for (int i = 0; i < 100 && sb_b.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t6_drained", 64'(sb_b.size()), 64'd0);
        check("t6_delivered", 64'(delivered_b), 64'd10000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
